// File: rtl/thread_pkg.sv
// -----------------------------------------------------------------------------
// thread_pkg
// Shared definitions for the per-thread fetch slice.
//   AW / DW        : instruction-address and instruction widths
//   fetch_state_e  : fetch sequencer state (IDLE, RUN, HALT)
//   qent_t         : one fetch-queue entry (valid, address, instruction word)
//   pc_inc         : program-counter increment, wraps modulo 2^AW
// -----------------------------------------------------------------------------
package thread_pkg;

    localparam int AW = 10;
    localparam int DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] pc;
        logic [DW-1:0] ins;
    } qent_t;

    function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] pc);
        return pc + AW'(1);
    endfunction

endpackage

// File: rtl/thread_fetch_if.sv
// -----------------------------------------------------------------------------
// thread_fetch_if
// Bus bundle between the fetch sequencer, its instruction memory and the
// thread's decode stage.
//   imem_en / imem_addr / imem_rdata : synchronous instruction-memory read port
//   ins / ins_valid / ins_ready / ins_pc : instruction handshake to decode
//   dec_*                            : control-flow feedback from decode,
//                                      meaningful only on a consume cycle
// master = fetch sequencer side, slave = memory/decode side.
// -----------------------------------------------------------------------------
interface thread_fetch_if;
    import thread_pkg::*;

    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic [DW-1:0] ins;
    logic          ins_valid;
    logic          ins_ready;
    logic [AW-1:0] ins_pc;
    logic          dec_jump;
    logic [AW-1:0] dec_jump_addr;
    logic          dec_push;
    logic [AW-1:0] dec_tos_addr;
    logic          dec_pop;
    logic          dec_halt;

    modport master (
        output imem_en, imem_addr, ins, ins_valid, ins_pc,
        input  imem_rdata, ins_ready, dec_jump, dec_jump_addr,
               dec_push, dec_tos_addr, dec_pop, dec_halt
    );

    modport slave (
        input  imem_en, imem_addr, ins, ins_valid, ins_pc,
        output imem_rdata, ins_ready, dec_jump, dec_jump_addr,
               dec_push, dec_tos_addr, dec_pop, dec_halt
    );

endinterface

// File: rtl/thread_fetch_tos_stack.sv
// -----------------------------------------------------------------------------
// tos_stack
// Circular LIFO holding return/TOS addresses.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous empty (pointer and count cleared, data kept)
//   push/push_data : push a value; when full the oldest entry is overwritten
//   pop/pop_data   : pop the top; pop_data is 0 when the stack is empty
//   ovf / unf      : single-cycle overflow / underflow indications
// push together with pop on a non-empty stack replaces the top entry after it
// has been read, leaving depth unchanged.
// -----------------------------------------------------------------------------
module tos_stack #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         ovf,
    output logic         unf
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] ptr_r;
    logic [PW:0]   cnt_r;
    logic [PW-1:0] top_s;
    logic          empty_s;
    logic          full_s;

    // Occupancy decode, top-of-stack read and error flags
    always_comb begin
        empty_s = (cnt_r == '0);
        full_s  = (cnt_r == (PW+1)'(DEPTH));
        top_s   = ptr_r - PW'(1);
        if (pop && !empty_s) begin
            pop_data = mem_r[top_s];
        end else begin
            pop_data = '0;
        end
        unf = pop & empty_s;
        ovf = push & full_s & ~(pop & ~empty_s);
    end

    // Stack storage, write pointer and depth counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
            cnt_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clr) begin
            ptr_r <= '0;
            cnt_r <= '0;
        end else if (pop && !empty_s && push) begin
            mem_r[top_s] <= push_data;
        end else if (pop && !empty_s) begin
            ptr_r <= top_s;
            cnt_r <= cnt_r - (PW+1)'(1);
        end else if (push) begin
            // When full, ptr_r already points at the oldest entry
            mem_r[ptr_r] <= push_data;
            ptr_r        <= ptr_r + PW'(1);
            if (!full_s) begin
                cnt_r <= cnt_r + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/thread_fetch.sv
// -----------------------------------------------------------------------------
// thread_fetch
// Per-thread instruction fetch sequencer. Owns the PC, issues synchronous
// reads to instruction memory, buffers returned words in a 2-entry queue and
// presents the head to decode. Decode reports jump / push / pop / halt when
// it consumes an instruction.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, start_pc : leave IDLE/HALT and fetch from start_pc (ignored in RUN)
//   bus (master)    : memory read port and decode handshake (thread_fetch_if)
//   halted / busy   : state is HALT / RUN
//   stk_err         : sticky stack overflow/underflow, cleared by start
// A read issued in cycle c returns in c+1 and reaches the queue head in c+2.
// -----------------------------------------------------------------------------
module thread_fetch
    import thread_pkg::*;
#(
    parameter int STK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW-1:0]   start_pc,
    thread_fetch_if.master  bus,
    output logic            halted,
    output logic            busy,
    output logic            stk_err
);

    fetch_state_e  state_r, state_s;
    qent_t         q0_r, q1_r, q0_s, q1_s, new_s;
    logic [AW-1:0] pc_r, pc_s;
    logic          inflight_r;
    logic [AW-1:0] inflight_pc_r;
    logic          stk_err_r, stk_err_s;

    logic          start_s;
    logic          consume_s;
    logic          halt_s;
    logic          pop_s;
    logic          jump_s;
    logic          push_s;
    logic          redirect_s;
    logic [2:0]    occ_s;
    logic          issue_s;
    logic [AW-1:0] pop_data_s;
    logic          ovf_s;
    logic          unf_s;

    tos_stack #(
        .W     (AW),
        .DEPTH (STK_DEPTH)
    ) u_tos_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_s),
        .push      (push_s),
        .push_data (bus.dec_tos_addr),
        .pop       (pop_s),
        .pop_data  (pop_data_s),
        .ovf       (ovf_s),
        .unf       (unf_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            RUN: begin
                if (halt_s) state_s = HALT;
                else        state_s = RUN;
            end
            HALT: begin
                if (start) state_s = RUN;
                else       state_s = HALT;
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs: decode feedback qualification and the issue decision
    always_comb begin
        start_s    = start & (state_r != RUN);
        consume_s  = q0_r.valid & bus.ins_ready;
        // halt > pop > jump; push rides along with whatever else happens
        halt_s     = consume_s & bus.dec_halt;
        pop_s      = consume_s & bus.dec_pop & ~bus.dec_halt;
        jump_s     = consume_s & bus.dec_jump & ~bus.dec_halt & ~bus.dec_pop;
        push_s     = consume_s & bus.dec_push;
        redirect_s = pop_s | jump_s;
        // Slots already claimed once this cycle's consume is accounted for
        occ_s      = 3'(q0_r.valid) + 3'(q1_r.valid) + 3'(inflight_r) - 3'(consume_s);
        issue_s    = (state_r == RUN) & ~halt_s & ~redirect_s & (occ_s < 3'd2);
        bus.imem_en   = issue_s;
        bus.imem_addr = pc_r;
        busy          = (state_r == RUN);
        halted        = (state_r == HALT);
    end

    // Queue, PC and error-flag next values
    always_comb begin
        q0_s      = q0_r;
        q1_s      = q1_r;
        pc_s      = pc_r;
        stk_err_s = stk_err_r;
        new_s     = {1'b1, inflight_pc_r, bus.imem_rdata};

        if (start_s) begin
            q0_s = '0;
            q1_s = '0;
            pc_s = start_pc;
        end else if (state_r != RUN) begin
            q0_s = q0_r;
        end else if (halt_s) begin
            // The returning word is simply not written: that is the discard
            q0_s = '0;
            q1_s = '0;
        end else if (redirect_s) begin
            q0_s = '0;
            q1_s = '0;
            if (pop_s) pc_s = pop_data_s;
            else       pc_s = bus.dec_jump_addr;
        end else begin
            if (consume_s) begin
                q0_s = q1_r;
                q1_s = '0;
            end else begin
                q0_s = q0_r;
            end
            if (inflight_r) begin
                if (!q0_s.valid) q0_s = new_s;
                else             q1_s = new_s;
            end else begin
                q1_s = q1_s;
            end
            if (issue_s) pc_s = pc_inc(pc_r);
            else         pc_s = pc_r;
        end

        if (start_s) begin
            stk_err_s = 1'b0;
        end else if (ovf_s || unf_s) begin
            stk_err_s = 1'b1;
        end else begin
            stk_err_s = stk_err_r;
        end
    end

    // Datapath registers: queue, PC, outstanding read tracking, error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0_r          <= '0;
            q1_r          <= '0;
            pc_r          <= '0;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
            stk_err_r     <= 1'b0;
        end else begin
            q0_r       <= q0_s;
            q1_r       <= q1_s;
            pc_r       <= pc_s;
            inflight_r <= issue_s;
            stk_err_r  <= stk_err_s;
            if (issue_s) begin
                inflight_pc_r <= pc_r;
            end
        end
    end

    assign bus.ins       = q0_r.ins;
    assign bus.ins_valid = q0_r.valid;
    assign bus.ins_pc    = q0_r.pc;
    assign stk_err       = stk_err_r;

endmodule
